// File: rtl/axi2apb_bridge.sv
// axi2apb_bridge
//   AXI4 slave -> APB3 master bridge for the peripheral window. One AXI
//   transaction is in flight at a time. Each AXI beat becomes one 32-bit APB
//   transfer on the 32-bit lane of the 64-bit data bus selected by addr[2].
//   Beats of size 3 (64-bit) are not forwarded; they complete with SLVERR.
// Ports
//   clk, rst_n             clock, async active-low reset
//   slave_aw_* / slave_w_* AXI write address / data channels (in)
//   slave_b_*              AXI write response channel (out)
//   slave_ar_*             AXI read address channel (in)
//   slave_r_*              AXI read data channel (out)
//   psel/penable/pwrite/paddr/pwdata   APB master request (out)
//   prdata/pready/pslverr               APB completion (in)
module axi2apb_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 2,
  parameter int AXI_USER_WIDTH = 0,
  parameter int APB_ADDR_WIDTH = 32,
  localparam int UW = (AXI_USER_WIDTH > 0) ? AXI_USER_WIDTH : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // AW
  input  logic [AXI_ID_WIDTH-1:0]   slave_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] slave_aw_addr,
  input  logic [7:0]                slave_aw_len,
  input  logic [2:0]                slave_aw_size,
  input  logic [1:0]                slave_aw_burst,
  input  logic                      slave_aw_valid,
  output logic                      slave_aw_ready,
  // W
  input  logic [AXI_DATA_WIDTH-1:0] slave_w_data,
  input  logic                      slave_w_last,
  input  logic                      slave_w_valid,
  output logic                      slave_w_ready,
  // B
  output logic [AXI_ID_WIDTH-1:0]   slave_b_id,
  output logic [1:0]                slave_b_resp,
  output logic [UW-1:0]             slave_b_user,
  output logic                      slave_b_valid,
  input  logic                      slave_b_ready,
  // AR
  input  logic [AXI_ID_WIDTH-1:0]   slave_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] slave_ar_addr,
  input  logic [7:0]                slave_ar_len,
  input  logic [2:0]                slave_ar_size,
  input  logic [1:0]                slave_ar_burst,
  input  logic                      slave_ar_valid,
  output logic                      slave_ar_ready,
  // R
  output logic [AXI_ID_WIDTH-1:0]   slave_r_id,
  output logic [AXI_DATA_WIDTH-1:0] slave_r_data,
  output logic [1:0]                slave_r_resp,
  output logic                      slave_r_last,
  output logic [UW-1:0]             slave_r_user,
  output logic                      slave_r_valid,
  input  logic                      slave_r_ready,
  // APB
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic [31:0]               pwdata,
  input  logic [31:0]               prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_W, S_SETUP, S_ACCESS, S_WR_RESP, S_RD_RESP
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [AXI_ID_WIDTH-1:0]   r_axi_id;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len, r_beat;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic                      r_write;
  logic                      r_wr_err;   // sticky over the whole write burst
  logic                      r_rd_err;   // error of the current read beat
  logic [31:0]               r_prdata;
  logic [31:0]               r_pwdata;
  logic                      r_prio_wr;  // 1: write wins the next AW/AR collision

  logic                      w_aw_grant, w_ar_grant, w_last_beat, w_wide;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_nxt;
  logic                      w_unused;

  // w_last is informational only; the latched len decides the last beat.
  assign w_unused = slave_w_last;

  assign w_aw_grant  = (r_state == S_IDLE) && slave_aw_valid && (!slave_ar_valid || r_prio_wr);
  assign w_ar_grant  = (r_state == S_IDLE) && slave_ar_valid && !w_aw_grant;
  assign w_last_beat = (r_beat == r_len);
  assign w_wide      = (r_size >= 3'd3);
  // WRAP behaves like INCR; FIXED keeps the address. Wraps modulo 2^AXI_ADDR_WIDTH.
  assign w_addr_nxt  = (r_burst == 2'b00) ? r_addr
                                           : r_addr + (AXI_ADDR_WIDTH'(1) << r_size);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    slave_aw_ready = w_aw_grant;
    slave_ar_ready = w_ar_grant;
    slave_w_ready  = 1'b0;
    slave_b_valid  = 1'b0;
    slave_r_valid  = 1'b0;
    psel           = 1'b0;
    penable        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_aw_grant)      w_state_nxt = S_WAIT_W;
        else if (w_ar_grant) w_state_nxt = (slave_ar_size >= 3'd3) ? S_RD_RESP : S_SETUP;
      end
      S_WAIT_W: begin
        slave_w_ready = 1'b1;
        if (slave_w_valid) begin
          if (!w_wide)          w_state_nxt = S_SETUP;
          else if (w_last_beat) w_state_nxt = S_WR_RESP;
        end
      end
      S_SETUP: begin
        psel        = 1'b1;
        w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          if (!r_write)         w_state_nxt = S_RD_RESP;
          else if (w_last_beat) w_state_nxt = S_WR_RESP;
          else                  w_state_nxt = S_WAIT_W;
        end
      end
      S_RD_RESP: begin
        slave_r_valid = 1'b1;
        if (slave_r_ready) begin
          if (w_last_beat) w_state_nxt = S_IDLE;
          else if (!w_wide) w_state_nxt = S_SETUP;
        end
      end
      S_WR_RESP: begin
        slave_b_valid = 1'b1;
        if (slave_b_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_axi_id  <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_write   <= 1'b0;
      r_wr_err  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_prdata  <= '0;
      r_pwdata  <= '0;
      r_prio_wr <= 1'b1;
    end else begin
      if (w_aw_grant) begin
        r_axi_id  <= slave_aw_id;
        r_addr    <= slave_aw_addr;
        r_len     <= slave_aw_len;
        r_size    <= slave_aw_size;
        r_burst   <= slave_aw_burst;
        r_write   <= 1'b1;
        r_beat    <= '0;
        r_wr_err  <= 1'b0;
        r_prio_wr <= 1'b0;
      end else if (w_ar_grant) begin
        r_axi_id  <= slave_ar_id;
        r_addr    <= slave_ar_addr;
        r_len     <= slave_ar_len;
        r_size    <= slave_ar_size;
        r_burst   <= slave_ar_burst;
        r_write   <= 1'b0;
        r_beat    <= '0;
        r_wr_err  <= 1'b0;
        r_prio_wr <= 1'b1;
        // 64-bit reads never reach APB: answer zero data with SLVERR.
        r_prdata  <= '0;
        r_rd_err  <= (slave_ar_size >= 3'd3);
      end

      if (r_state == S_WAIT_W && slave_w_valid) begin
        r_pwdata <= r_addr[2] ? slave_w_data[63:32] : slave_w_data[31:0];
        if (w_wide) begin
          r_wr_err <= 1'b1;
          if (!w_last_beat) begin
            r_beat <= r_beat + 8'd1;
            r_addr <= w_addr_nxt;
          end
        end
      end

      if (r_state == S_ACCESS && pready) begin
        if (r_write) begin
          r_wr_err <= r_wr_err | pslverr;
          if (!w_last_beat) begin
            r_beat <= r_beat + 8'd1;
            r_addr <= w_addr_nxt;
          end
        end else begin
          r_prdata <= prdata;
          r_rd_err <= pslverr;
        end
      end

      if (r_state == S_RD_RESP && slave_r_ready && !w_last_beat) begin
        r_beat <= r_beat + 8'd1;
        r_addr <= w_addr_nxt;
      end
    end
  end

  assign pwrite       = r_write;
  assign paddr        = r_addr[APB_ADDR_WIDTH-1:0];
  assign pwdata       = r_pwdata;
  assign slave_b_id   = r_axi_id;
  assign slave_b_resp = r_wr_err ? 2'b10 : 2'b00;
  assign slave_b_user = '0;
  assign slave_r_id   = r_axi_id;
  assign slave_r_data = {r_prdata, r_prdata};
  assign slave_r_resp = r_rd_err ? 2'b10 : 2'b00;
  assign slave_r_last = w_last_beat;
  assign slave_r_user = '0;

endmodule

// File: tb/tb_axi2apb_bridge.sv
module tb_axi2apb_bridge;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [63:0] w_data, r_data;
  logic        w_last, w_valid, w_ready;
  logic [1:0]  b_resp, r_resp;
  logic        b_user, r_user;
  logic        b_valid, b_ready, r_last, r_valid, r_ready;
  logic        penable, pwrite, psel, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  axi2apb_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .slave_aw_id(aw_id), .slave_aw_addr(aw_addr), .slave_aw_len(aw_len),
    .slave_aw_size(aw_size), .slave_aw_burst(aw_burst),
    .slave_aw_valid(aw_valid), .slave_aw_ready(aw_ready),
    .slave_w_data(w_data), .slave_w_last(w_last), .slave_w_valid(w_valid),
    .slave_w_ready(w_ready),
    .slave_b_id(b_id), .slave_b_resp(b_resp), .slave_b_user(b_user),
    .slave_b_valid(b_valid), .slave_b_ready(b_ready),
    .slave_ar_id(ar_id), .slave_ar_addr(ar_addr), .slave_ar_len(ar_len),
    .slave_ar_size(ar_size), .slave_ar_burst(ar_burst),
    .slave_ar_valid(ar_valid), .slave_ar_ready(ar_ready),
    .slave_r_id(r_id), .slave_r_data(r_data), .slave_r_resp(r_resp),
    .slave_r_last(r_last), .slave_r_user(r_user), .slave_r_valid(r_valid),
    .slave_r_ready(r_ready),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .psel(psel),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- APB slave responder / monitor ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } apb_t;
  apb_t        apb_q[$];
  bit          err_pat[$];
  logic [31:0] rdata_pat[$];
  int          force_wait = -1;
  int          last_acc   = 0;
  int          psel_cnt   = 0;

  initial begin
    bit          in_acc = 0;
    int          wait_left = 0;
    int          acc_cnt = 0;
    logic [31:0] setup_addr = '0;
    apb_t        e;
    pready = 0; prdata = '0; pslverr = 0;
    forever begin
      @(negedge clk);
      pready = 0; pslverr = 0;
      if (psel) psel_cnt++;
      if (!rst_n) in_acc = 0;
      else if (psel && !penable) setup_addr = paddr;
      else if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1; acc_cnt = 0;
          wait_left = (force_wait >= 0) ? force_wait : $urandom_range(0, 2);
        end
        acc_cnt++;
        chk("paddr_stable", paddr, setup_addr);
        if (wait_left > 0) wait_left--;
        else begin
          pready  = 1;
          prdata  = (rdata_pat.size() > 0) ? rdata_pat.pop_front() : $urandom;
          pslverr = (err_pat.size() > 0) ? err_pat.pop_front() : ($urandom_range(0, 3) == 0);
          e.addr = paddr; e.wr = pwrite; e.wdata = pwdata; e.err = pslverr; e.rdata = prdata;
          apb_q.push_back(e);
          last_acc = acc_cnt;
          in_acc = 0;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b00) return a;
    return a + k * (32'd1 << size);
  endfunction

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [1:0]  id;
  } rbeat_t;
  rbeat_t      rq[$];
  logic [63:0] wd_q[$];
  logic [1:0]  b_resp_got, b_id_got;
  int          hs_cyc, first_rv;

  task automatic aw_send(input logic [1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    aw_id = id; aw_addr = a; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1;
    for (int g = 0; g < 300 && !ok; g++) begin
      #1;
      if (aw_ready) ok = 1;
      @(negedge clk);
    end
    aw_valid = 0;
    chk("aw_hs", ok, 1);
  endtask

  task automatic ar_send(input logic [1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit ok = 0;
    ar_id = id; ar_addr = a; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1;
    for (int g = 0; g < 300 && !ok; g++) begin
      #1;
      if (ar_ready) begin ok = 1; hs_cyc = cyc; end
      @(negedge clk);
    end
    ar_valid = 0;
    chk("ar_hs", ok, 1);
  endtask

  task automatic w_send(input int len);
    for (int i = 0; i <= len; i++) begin
      bit ok = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w_data = {$urandom, $urandom}; w_last = (i == len); w_valid = 1;
      for (int g = 0; g < 300 && !ok; g++) begin
        #1;
        if (w_ready) ok = 1;
        @(negedge clk);
      end
      w_valid = 0;
      chk("w_hs", ok, 1);
      wd_q.push_back(w_data);
    end
  endtask

  task automatic b_recv();
    bit got = 0;
    for (int g = 0; g < 300 && !got; g++) begin
      b_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (b_valid && b_ready) begin got = 1; b_resp_got = b_resp; b_id_got = b_id; end
      @(negedge clk);
    end
    b_ready = 0;
    chk("b_hs", got, 1);
  endtask

  task automatic r_recv(input int nb);
    int     n = 0;
    rbeat_t rb;
    first_rv = -1;
    for (int g = 0; g < 600 && n < nb; g++) begin
      r_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (r_valid) begin
        if (first_rv < 0) first_rv = cyc;
        if (r_ready) begin
          rb.data = r_data; rb.resp = r_resp; rb.last = r_last; rb.id = r_id;
          rq.push_back(rb); n++;
        end
      end
      @(negedge clk);
    end
    r_ready = 0;
    chk("r_beats", n, nb);
  endtask

  task automatic check_write(input logic [1:0] id, input logic [31:0] a, input int len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic        err_any;
    logic [31:0] ea;
    int          n;
    err_any = (size == 3);
    n = (size == 3) ? 0 : len + 1;
    chk("w_apb_cnt", apb_q.size(), n);
    for (int k = 0; k < n && k < apb_q.size() && k < wd_q.size(); k++) begin
      ea = beat_addr(a, k, size, burst);
      chk("w_paddr", apb_q[k].addr, ea);
      chk("w_pwrite", apb_q[k].wr, 1);
      chk("w_pwdata", apb_q[k].wdata, ea[2] ? wd_q[k][63:32] : wd_q[k][31:0]);
      err_any |= apb_q[k].err;
    end
    chk("b_resp", b_resp_got, err_any ? 2'b10 : 2'b00);
    chk("b_id", b_id_got, id);
  endtask

  task automatic check_read(input logic [1:0] id, input logic [31:0] a, input int len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] ed;
    logic [1:0]  er;
    chk("r_apb_cnt", apb_q.size(), (size == 3) ? 0 : len + 1);
    for (int k = 0; k <= len && k < rq.size(); k++) begin
      ed = '0; er = 2'b10;
      if (size != 3 && k < apb_q.size()) begin
        chk("r_paddr", apb_q[k].addr, beat_addr(a, k, size, burst));
        chk("r_pwrite", apb_q[k].wr, 0);
        ed = {apb_q[k].rdata, apb_q[k].rdata};
        er = apb_q[k].err ? 2'b10 : 2'b00;
      end
      chk("r_data", rq[k].data, ed);
      chk("r_resp", rq[k].resp, er);
      chk("r_last", rq[k].last, (k == len));
      chk("r_id", rq[k].id, id);
    end
  endtask

  task automatic run_write(input logic [1:0] id, input logic [31:0] a, input int len,
                           input logic [2:0] size, input logic [1:0] burst);
    apb_q.delete(); wd_q.delete();
    aw_send(id, a, len[7:0], size, burst);
    w_send(len);
    b_recv();
    check_write(id, a, len, size, burst);
  endtask

  task automatic run_read(input logic [1:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    apb_q.delete(); rq.delete();
    ar_send(id, a, len[7:0], size, burst);
    r_recv(len + 1);
    check_read(id, a, len, size, burst);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int p0;
    bit ok;
    logic [2:0] sz;
    rst_n = 0;
    aw_valid = 0; ar_valid = 0; w_valid = 0; b_ready = 0; r_ready = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    w_data = 0; w_last = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
    chk("rst_axi", {aw_ready, ar_ready, w_ready, b_valid, r_valid}, '0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // single read, fixed latency
    force_wait = 0; err_pat.push_back(0); rdata_pat.push_back(32'hCAFE_F00D);
    run_read(2'd1, 32'h1A10_1004, 0, 3'd2, 2'b01);
    chk("t1_lat", first_rv - hs_cyc, 3);
    if (rq.size() > 0) chk("t1_data", rq[0].data, 64'hCAFEF00D_CAFEF00D);
    force_wait = -1;

    // 4-beat INCR write, lanes lo/hi/lo/hi
    err_pat = '{0, 0, 0, 0};
    run_write(2'd2, 32'h1A10_0000, 3, 3'd2, 2'b01);

    // reset so that the arbiter pointer is back at write-first
    rst_n = 0; @(negedge clk); rst_n = 1; @(negedge clk);

    // collision: write first, then read wins against a fresh AW
    apb_q.delete(); wd_q.delete();
    ar_id = 2'd3; ar_addr = 32'h1A10_0020; ar_len = 0; ar_size = 3'd2; ar_burst = 2'b01;
    aw_id = 2'd1; aw_addr = 32'h1A10_0010; aw_len = 0; aw_size = 3'd2; aw_burst = 2'b01;
    aw_valid = 1; ar_valid = 1;
    #1;
    chk("c1_aw_rdy", aw_ready, 1);
    chk("c1_ar_rdy", ar_ready, 0);
    aw_send(2'd1, 32'h1A10_0010, 0, 3'd2, 2'b01);
    w_send(0);
    b_recv();
    check_write(2'd1, 32'h1A10_0010, 0, 3'd2, 2'b01);
    aw_id = 2'd0; aw_addr = 32'h1A10_0030; aw_valid = 1;
    #1;
    chk("c2_ar_rdy", ar_ready, 1);
    chk("c2_aw_rdy", aw_ready, 0);
    apb_q.delete(); rq.delete();
    ar_send(2'd3, 32'h1A10_0020, 0, 3'd2, 2'b01);
    r_recv(1);
    check_read(2'd3, 32'h1A10_0020, 0, 3'd2, 2'b01);
    apb_q.delete(); wd_q.delete();
    aw_send(2'd0, 32'h1A10_0030, 0, 3'd2, 2'b01);
    w_send(0);
    b_recv();
    check_write(2'd0, 32'h1A10_0030, 0, 3'd2, 2'b01);

    // slow slave then error
    force_wait = 5; err_pat.push_back(1);
    run_read(2'd2, 32'h1A10_0100, 0, 3'd2, 2'b01);
    chk("t4_acc_cycles", last_acc, 6);
    if (rq.size() > 0) chk("t4_resp", rq[0].resp, 2'b10);
    force_wait = -1;

    // sticky write error, then a 64-bit read that never touches APB
    err_pat = '{1, 0};
    run_write(2'd1, 32'h1A10_0200, 1, 3'd2, 2'b01);
    chk("t5_bresp", b_resp_got, 2'b10);
    p0 = psel_cnt;
    run_read(2'd0, 32'h1A10_0208, 0, 3'd3, 2'b01);
    chk("t5_nopsel", psel_cnt - p0, 0);

    // address arithmetic wraps at 2^32
    run_read(2'd1, 32'hFFFF_FFFC, 1, 3'd2, 2'b01);

    // reset during ACCESS
    apb_q.delete(); force_wait = 1000;
    ar_send(2'd2, 32'h1A10_0040, 0, 3'd2, 2'b01);
    ok = 0;
    for (int g = 0; g < 20 && !ok; g++) begin
      #1;
      if (psel && penable) ok = 1;
      else @(negedge clk);
    end
    chk("t6_in_access", ok, 1);
    #1 rst_n = 0;
    #1;
    chk("t6_psel", psel, 0);
    chk("t6_penable", penable, 0);
    chk("t6_valids", {r_valid, b_valid}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1; force_wait = -1;
    @(negedge clk);
    run_read(2'd3, 32'h1A10_0044, 0, 3'd2, 2'b01);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  id;
      logic [1:0]  bu;
      logic [31:0] a;
      int          len;
      id  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 3);
      sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      bu  = 2'($urandom_range(0, 2));
      a   = 32'h1A10_0000 + ($urandom_range(0, 32'h1FFFF) & ~((32'd1 << sz) - 1));
      if ($urandom_range(0, 1) == 1) run_write(id, a, len, sz, bu);
      else                           run_read(id, a, len, sz, bu);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
